// File: rtl/odometer_pkg.sv
// Shared types and defaults for the odometer measurement sequencer.
// No logic; state encoding, saturation word and default sizes only.
package odometer_pkg;

  localparam int NCH_DEF = 4;
  localparam int CW_DEF  = 12;
  localparam int DZW_DEF = 16;

  localparam logic [CW_DEF-1:0] SAT_VAL = {CW_DEF{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/detect_sync_edge.sv
// Three-flop synchronizer with falling-edge detect on the last two stages.
// Async edge to FALL high: 2 CLK edges; FALL is a one-cycle pulse, no backpressure.
module detect_sync_edge (
  input  logic CLK,
  input  logic RESETB,
  input  logic DETECT_ASYNC,
  output logic FALL
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= DETECT_ASYNC;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign FALL = ~s2_q & s3_q;

endmodule

// File: rtl/odometer_meas_sequencer.sv
// One clear/run/drain measurement over NCH odometer channels; capture lands 3 CLK after an async DETECT fall.
// Readout holds each word until RD_READY; one word per cycle when RD_READY stays high.
module odometer_meas_sequencer
  import odometer_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int CW  = CW_DEF,
  parameter int DZW = DZW_DEF,
  parameter int CHW = 2
) (
  input  logic              CLK,
  input  logic              RESETB,
  input  logic              START,
  input  logic [NCH-1:0]    CFG_CH_MASK,
  input  logic [DZW-1:0]    CFG_DZ_LIMIT,
  input  logic [NCH-1:0]    DETECT_ASYNC,
  input  logic [NCH*CW-1:0] BF_COUNT,
  output logic              BF_CLR,
  output logic              BF_EN,
  output logic              DZ_EXPIRE,
  output logic              BUSY,
  output logic              RD_VALID,
  input  logic              RD_READY,
  output logic [CHW-1:0]    RD_CH,
  output logic [CW-1:0]     RD_DATA,
  output logic              RD_SAT,
  output logic              DONE
);

  state_t state_q, state_d;

  logic [NCH-1:0] mask_q, done_q, sat_q, fall, cap_hit;
  logic [DZW-1:0] limit_q, dz_q;
  logic [CW-1:0]  cap_q [NCH];
  logic [CHW-1:0] rd_idx_q, first_idx, nxt_idx;
  logic           nxt_found, start_ok, run, expire, all_done, last_acc, done_pls_q;

  for (genvar g = 0; g < NCH; g++) begin : g_sync
    detect_sync_edge u_sync (
      .CLK          (CLK),
      .RESETB       (RESETB),
      .DETECT_ASYNC (DETECT_ASYNC[g]),
      .FALL         (fall[g])
    );
  end

  assign start_ok = START && (CFG_CH_MASK != '0);
  assign run      = (state_q == ST_RUN);
  assign expire   = run && (dz_q == limit_q);
  assign cap_hit  = run ? (fall & mask_q & ~done_q) : '0;
  assign all_done = ((done_q | cap_hit) & mask_q) == mask_q;
  assign last_acc = (state_q == ST_DRAIN) && RD_READY && !nxt_found;

  // Lowest masked channel, and the next masked channel above the one on the bus.
  always_comb begin
    first_idx = '0;
    nxt_idx   = '0;
    nxt_found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask_q[i]) first_idx = CHW'(i);
      if (mask_q[i] && (i > int'(rd_idx_q))) begin
        nxt_idx   = CHW'(i);
        nxt_found = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_RUN;
      ST_RUN:   if (all_done || expire) state_d = ST_DRAIN;
      ST_DRAIN: if (last_acc) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    BF_CLR    = (state_q == ST_CLEAR);
    BF_EN     = run;
    DZ_EXPIRE = expire;
    BUSY      = (state_q != ST_IDLE);
    RD_VALID  = (state_q == ST_DRAIN);
    RD_CH     = RD_VALID ? rd_idx_q : '0;
    RD_DATA   = RD_VALID ? cap_q[rd_idx_q] : '0;
    RD_SAT    = RD_VALID ? sat_q[rd_idx_q] : 1'b0;
    DONE      = done_pls_q;
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      mask_q     <= '0;
      limit_q    <= '0;
      dz_q       <= '0;
      done_q     <= '0;
      sat_q      <= '0;
      rd_idx_q   <= '0;
      done_pls_q <= 1'b0;
      for (int i = 0; i < NCH; i++) cap_q[i] <= '0;
    end else begin
      done_pls_q <= last_acc;
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            mask_q  <= CFG_CH_MASK;
            limit_q <= CFG_DZ_LIMIT;
          end
        end
        ST_CLEAR: begin
          dz_q   <= '0;
          done_q <= '0;
          sat_q  <= '0;
        end
        ST_RUN: begin
          // Counter parks at the limit so it can never wrap past it.
          if (!expire) dz_q <= dz_q + DZW'(1);
          for (int i = 0; i < NCH; i++) begin
            if (cap_hit[i]) begin
              cap_q[i]  <= BF_COUNT[i*CW +: CW];
              done_q[i] <= 1'b1;
            end else if (expire && mask_q[i] && !done_q[i]) begin
              cap_q[i]  <= {CW{1'b1}};
              done_q[i] <= 1'b1;
              sat_q[i]  <= 1'b1;
            end
          end
          if (all_done || expire) rd_idx_q <= first_idx;
        end
        ST_DRAIN: begin
          if (RD_READY && nxt_found) rd_idx_q <= nxt_idx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_odometer_meas_sequencer.sv
// Directed bench: table of measurement vectors with hand-computed words, plus reset-abort sequences.
module tb_odometer_meas_sequencer;

  logic        CLK, RESETB, START, RD_READY;
  logic [3:0]  CFG_CH_MASK, DETECT_ASYNC;
  logic [15:0] CFG_DZ_LIMIT;
  logic [47:0] BF_COUNT;
  logic        BF_CLR, BF_EN, DZ_EXPIRE, BUSY, RD_VALID, RD_SAT, DONE;
  logic [1:0]  RD_CH;
  logic [11:0] RD_DATA;
  logic [20:0] outs;

  int nchk = 0;
  int nerr = 0;

  odometer_meas_sequencer dut (
    .CLK(CLK), .RESETB(RESETB), .START(START), .CFG_CH_MASK(CFG_CH_MASK),
    .CFG_DZ_LIMIT(CFG_DZ_LIMIT), .DETECT_ASYNC(DETECT_ASYNC), .BF_COUNT(BF_COUNT),
    .BF_CLR(BF_CLR), .BF_EN(BF_EN), .DZ_EXPIRE(DZ_EXPIRE), .BUSY(BUSY),
    .RD_VALID(RD_VALID), .RD_READY(RD_READY), .RD_CH(RD_CH), .RD_DATA(RD_DATA),
    .RD_SAT(RD_SAT), .DONE(DONE)
  );

  assign outs = {BF_CLR, BF_EN, DZ_EXPIRE, BUSY, RD_VALID, RD_CH, RD_DATA, RD_SAT, DONE};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]        mask;
    int                limit;
    logic [3:0][7:0]   cap;       // tb cycle of the DETECT fall; 8'hFF = never
    logic [3:0][11:0]  cnt;
    logic [3:0][11:0]  exp_data;
    logic [3:0]        exp_sat;
    int                exp_dz;    // RUN cycle of DZ_EXPIRE; -1 = none
    int                stall;
    bit                toggle2;
    int                restart;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_meas(input vec_t v);
    int stall_left, nw, dz_at, dz_n, clr_n, k;
    bit done_seen, busy_bad, ref_ok;
    logic [20:0] ref_outs;
    logic [1:0]  w_ch   [8];
    logic [11:0] w_data [8];
    logic        w_sat  [8];
    int          w_j    [8];
    stall_left = v.stall; nw = 0; dz_at = -1; dz_n = 0; clr_n = 0;
    done_seen = 0; busy_bad = 0; ref_ok = 0; ref_outs = '0;
    CFG_CH_MASK  = v.mask;
    CFG_DZ_LIMIT = 16'(v.limit);
    for (int j = 0; j < 400 && !done_seen; j++) begin
      @(posedge CLK); #1;
      START    = (j == 0) || (j == v.restart);
      RD_READY = (stall_left == 0);
      for (int i = 0; i < 4; i++) begin
        int c;
        c = int'(v.cap[i]);
        if (c == 255)                   DETECT_ASYNC[i] = 1'b1;
        else if (j < c)                 DETECT_ASYNC[i] = 1'b1;
        else if (v.toggle2 && i == 2)   DETECT_ASYNC[i] = (((j - c) / 4) % 2) != 0;
        else                            DETECT_ASYNC[i] = 1'b0;
        BF_COUNT[i*12 +: 12] = (c != 255 && j == c + 2) ? v.cnt[i] : 12'(12'h500 + j * 4 + i);
      end
      @(negedge CLK);
      if (BF_CLR) clr_n++;
      if (DZ_EXPIRE) begin
        dz_n++;
        if (dz_at < 0) dz_at = j - 2;
      end
      if (j >= 1 && !DONE && !BUSY) busy_bad = 1;
      if (RD_VALID) begin
        if (stall_left > 0) begin
          if (!ref_ok) begin
            ref_outs = outs;
            ref_ok   = 1;
          end else begin
            check("stall_stable", outs, ref_outs);
          end
          stall_left--;
        end else if (nw < 8) begin
          w_ch[nw] = RD_CH; w_data[nw] = RD_DATA; w_sat[nw] = RD_SAT; w_j[nw] = j;
          nw++;
        end
      end
      if (DONE) done_seen = 1;
    end
    START = 1'b0;
    RD_READY = 1'b1;
    DETECT_ASYNC = 4'hF;
    check("done_seen", done_seen, 1);
    check("bf_clr_pulses", clr_n, 1);
    check("dz_cycle", dz_at, v.exp_dz);
    check("dz_pulses", dz_n, (v.exp_dz >= 0) ? 1 : 0);
    check("busy_held", busy_bad, 0);
    check("word_count", nw, $countones(v.mask));
    k = 0;
    for (int ch = 0; ch < 4; ch++) begin
      if (v.mask[ch] && k < nw) begin
        check($sformatf("word%0d ch/sat/data", k), {w_ch[k], w_sat[k], w_data[k]},
              {2'(ch), v.exp_sat[ch], v.exp_data[ch]});
        k++;
      end
    end
    for (int m = 1; m < nw; m++) check("back_to_back", w_j[m], w_j[m-1] + 1);
    repeat (8) @(posedge CLK);
  endtask

  task automatic start_pulse(input logic [3:0] mask, input int limit);
    @(posedge CLK); #1;
    CFG_CH_MASK = mask; CFG_DZ_LIMIT = 16'(limit); START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic reset_now(input string tag);
    bit saw_done;
    saw_done = 0;
    @(posedge CLK); #2;
    RESETB = 1'b0;
    #1;
    check({tag, "_outs_zero"}, outs, '0);
    @(negedge CLK);
    RESETB = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (DONE) saw_done = 1;
    end
    check({tag, "_no_done"}, saw_done, 0);
    check({tag, "_idle"}, outs, '0);
  endtask

  initial begin
    bit got;
    vecs[0] = '{4'b1111, 1000, {8'd40, 8'd30, 8'd20, 8'd10}, {12'd8, 12'd7, 12'd6, 12'd5},
                {12'd8, 12'd7, 12'd6, 12'd5}, 4'b0000, -1, 0, 1'b0, -1};
    vecs[1] = '{4'b0101, 50, {8'hFF, 8'hFF, 8'd7, 8'd5}, {12'h0, 12'h0, 12'h0EE, 12'h123},
                {12'h0, 12'hFFF, 12'h0, 12'h123}, 4'b0100, 50, 0, 1'b0, -1};
    vecs[2] = '{4'b0111, 0, {8'hFF, 8'hFF, 8'd0, 8'hFF}, {12'h0, 12'h0, 12'h3C5, 12'h0},
                {12'h0, 12'hFFF, 12'h3C5, 12'hFFF}, 4'b0101, 0, 0, 1'b0, -1};
    vecs[3] = '{4'b0011, 1000, {8'hFF, 8'hFF, 8'd4, 8'd3}, {12'h0, 12'h0, 12'h0B2, 12'h0A1},
                {12'h0, 12'h0, 12'h0B2, 12'h0A1}, 4'b0000, -1, 7, 1'b0, -1};
    vecs[4] = '{4'b0110, 200, {8'hFF, 8'd6, 8'd40, 8'hFF}, {12'h0, 12'h2A2, 12'h0C1, 12'h0},
                {12'h0, 12'h2A2, 12'h0C1, 12'h0}, 4'b0000, -1, 0, 1'b1, 20};

    RESETB = 1'b0; START = 1'b0; CFG_CH_MASK = '0; CFG_DZ_LIMIT = '0;
    DETECT_ASYNC = 4'hF; BF_COUNT = '0; RD_READY = 1'b1;
    #3;
    check("reset_outs", outs, '0);
    repeat (2) @(negedge CLK);
    RESETB = 1'b1;
    repeat (4) @(posedge CLK);

    // START with an empty mask must not leave IDLE.
    start_pulse(4'b0000, 5);
    @(negedge CLK);
    check("empty_mask_ignored", BUSY, 0);

    for (int t = 0; t < 5; t++) run_meas(vecs[t]);

    start_pulse(4'b1111, 1000);
    repeat (3) @(posedge CLK);
    #1;
    check("pre_rst_run", {BUSY, BF_EN}, 2'b11);
    reset_now("rst_run");

    RD_READY = 1'b0;
    start_pulse(4'b0001, 3);
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge CLK);
      if (RD_VALID) got = 1;
    end
    check("drain_reached", got, 1);
    reset_now("rst_drain");
    RD_READY = 1'b1;

    run_meas(vecs[0]);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/odometer_meas_sequencer.md
Name: odometer_meas_sequencer

Overview:
Sequences one beat-frequency measurement across NCH stacked odometer channels.
- Clears and enables the shared beat-frequency counters, then runs a deadzone timeout.
- Captures each channel's count on the first synchronized falling edge of its DETECT; channels still open at timeout saturate to all-ones.
- Drains the captured words to the readout path over a valid/ready handshake.
- Sits between the chip control interface and the odometer datapath, replacing free-running per-channel latching with one controlled measurement window.

Parameters:
NCH, 4, number of odometer channels
CW, 12, beat-frequency count width
DZW, 16, deadzone counter width
CHW, 2, channel index width (clog2 of NCH)

Ports:
CLK  in  1  system clock
RESETB  in  1  reset, asynchronous, active-low
START  in  1  single-cycle measurement request
CFG_CH_MASK  in  NCH  channels taking part in the measurement; sampled on accepted START
CFG_DZ_LIMIT  in  DZW  deadzone timeout in RUN cycles; sampled on accepted START
DETECT_ASYNC  in  NCH  per-channel phase-detect, asynchronous to CLK
BF_COUNT  in  NCH*CW  live counter values; channel i is at bits [i*CW +: CW]
BF_CLR  out  1  synchronous clear to the counters
BF_EN  out  1  counter enable
DZ_EXPIRE  out  1  one-cycle pulse when the deadzone timeout fires
BUSY  out  1  high whenever the state is not IDLE
RD_VALID  out  1  readout word valid
RD_READY  in  1  readout sink ready
RD_CH  out  CHW  channel index of the current word
RD_DATA  out  CW  captured count
RD_SAT  out  1  current word saturated by timeout
DONE  out  1  one-cycle pulse at the end of the drain

Behaviour:
Reset:
- All outputs 0.
- FSM goes to IDLE.
- Capture registers, done bits, sat bits and synchronizers are cleared.
- Reset mid-measurement aborts immediately; no DONE pulse.

DETECT synchronization:
- Two-flop synchronizer per channel, plus a third flop for edge detection.
- Falling edge = stage2 low and stage3 high.
- Async edge to capture takes 3 CLK cycles.

FSM states: IDLE, CLEAR, RUN, DRAIN.

IDLE:
- START with nonzero CFG_CH_MASK is accepted: mask and limit are latched and the FSM goes to CLEAR.
- START with mask == 0 is ignored.
- START in any other state is ignored.

CLEAR (exactly 1 cycle):
- BF_CLR = 1, BF_EN = 0.
- Clears the deadzone counter, done bits and sat bits.
- Goes to RUN.

RUN:
- BF_EN = 1; the deadzone counter increments each cycle, starting from 0.
- Per masked channel without its done bit: a falling edge captures BF_COUNT for that channel and sets done.
- Later edges on a done channel are ignored. Unmasked channels are never captured.
- Exit 1: all masked channels done -> DRAIN, no DZ_EXPIRE.
- Exit 2: counter == latched limit -> DZ_EXPIRE pulse. Every masked channel still open is loaded with all-ones and its sat bit set. Then DRAIN.
- Limit 0 expires in the first RUN cycle.
- An edge in the same cycle as expiry: capture wins, value stored, sat = 0.
- The deadzone counter stops at the limit and never wraps.

DRAIN:
- BF_EN = 0; counter values are held.
- Presents masked channels in ascending index order.
- RD_VALID is high with stable RD_CH, RD_DATA and RD_SAT until RD_READY is sampled high; then it advances to the next masked channel.
- Back-to-back words are allowed: one word per cycle when RD_READY is held high.
- After the last word is accepted: DONE pulses, FSM goes to IDLE.

Width rules:
- RD_DATA is captured exactly as CW bits; no arithmetic is performed on it.
- The saturation value is {CW{1'b1}}.

Decomposition:
Shared package odometer_pkg holds:
- the FSM state enum
- the SAT value constant
- the default NCH, CW and DZW constants

One sub-module, detect_sync_edge: a 3-flop synchronizer plus falling-edge detector, instantiated NCH times.

Test Plan:
1. Mask 4'b1111, limit 1000, detects fall at staggered RUN cycles 10/20/30/40 with BF_COUNT = 5/6/7/8 -> four words ch0..3 with data 5/6/7/8, RD_SAT = 0, no DZ_EXPIRE, DONE after the fourth handshake.
2. Mask 4'b0101, limit 50, only ch0 detects (count 0x123) -> DZ_EXPIRE at RUN cycle 50; words ch0 = 0x123/sat 0, then ch2 = 0xFFF/sat 1; ch1 and ch3 are never output.
3. Limit 0, ch1 edge lands exactly in the first RUN cycle -> ch1 word holds the real count with sat 0; the other masked channels are 0xFFF with sat 1.
4. RD_READY held low 7 cycles during DRAIN -> RD_VALID, RD_CH and RD_DATA stay stable for all 7 cycles; the word advances 1 cycle after RD_READY rises.
5. Repeated DETECT toggles on ch2 with changing BF_COUNT -> only the first-edge value is reported. START pulsed during RUN is ignored: BUSY stays 1 and no restart occurs.
6. RESETB asserted mid-RUN and mid-DRAIN -> all outputs go to 0 asynchronously, no DONE; a following START runs a clean measurement with BF_CLR pulsed for 1 cycle.
